// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit handshake bundle: redirect input, instruction-memory
// request/response channel and the decode-side instruction channel.
//   master : fetch unit side (drives imem_req_*, inst_valid/data/pc)
//   slave  : environment side (memory, decode, next-PC logic)
interface pc_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: one outstanding imem request, holds the word for decode.
// Ports: clk, rst_n (async active-low), bus (pc_fetch_unit_if.master);
// misalign_err only when FETCH_MISALIGN_CHK_EN is defined.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst_n,
    pc_fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic misalign_err
`endif
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] inst_data_q, inst_pc_q;
    logic        started;
    logic        redir;
    logic [31:0] redir_tgt;
    logic        latch;

`ifdef FETCH_MISALIGN_CHK_EN
    logic bad_tgt;
    assign bad_tgt   = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    // A misaligned target is refused outright: no pc change, no flush.
    assign redir     = bus.redirect_valid && !bad_tgt;
    assign redir_tgt = bus.redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_err <= 1'b0;
        else if (bad_tgt)
            misalign_err <= 1'b1;
    end
`else
    assign redir     = bus.redirect_valid;
    assign redir_tgt = bus.redirect_pc & ~32'h3;
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        latch    = 1'b0;
        unique case (state)
            FETCH: begin
                if (redir)
                    pc_nx = redir_tgt;
                // An accepted request under redirect carries the old pc,
                // so its response must be thrown away.
                if (started && bus.imem_req_ready)
                    state_nx = redir ? DRAIN : WAIT;
            end
            WAIT: begin
                if (redir) begin
                    pc_nx    = redir_tgt;
                    state_nx = bus.imem_rsp_valid ? FETCH : DRAIN;
                end else if (bus.imem_rsp_valid) begin
                    latch    = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_nx    = redir_tgt;
                    state_nx = FETCH;
                end else if (bus.inst_ready) begin
                    pc_nx    = pc + 32'd4;
                    state_nx = FETCH;
                end
            end
            DRAIN: begin
                if (redir)
                    pc_nx = redir_tgt;
                if (bus.imem_rsp_valid)
                    state_nx = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            inst_data_q <= 32'h0;
            inst_pc_q   <= 32'h0;
            started     <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            started <= 1'b1;
            if (latch) begin
                inst_data_q <= bus.imem_rsp_data;
                inst_pc_q   <= pc;
            end
        end
    end

    // started keeps the request low through reset and the release edge.
    assign bus.imem_req_valid = started && (state == FETCH);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = (state == HOLD);
    assign bus.inst_data      = inst_data_q;
    assign bus.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: memory model returns ~addr,
// monitor pops expected {pc, word} on every decode handshake.
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   hs_count = 0;
    int   hs_cyc [64];
    int   mem_lat = 1;
    bit   rst_inject = 1'b0;
    exp_t exp_q [$];

    pc_fetch_unit_if bus ();

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_err;
    pc_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .misalign_err(misalign_err)
    );
`else
    pc_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.data = ~a;
        exp_q.push_back(e);
    endtask

    // Memory: samples acceptance at negedge, answers mem_lat cycles later.
    initial begin
        bit          fire;
        bit          busy;
        int          cnt;
        logic [31:0] a;
        logic [31:0] paddr;
        busy = 1'b0;
        cnt = 0;
        paddr = 32'h0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        forever begin
            @(negedge clk);
            fire = rst_n && bus.imem_req_valid && bus.imem_req_ready;
            a = bus.imem_req_addr;
            @(posedge clk);
            #2;
            bus.imem_rsp_valid = 1'b0;
            if (rst_inject) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data = 32'hDEAD_BEEF;
            end
            if (fire) begin
                busy = 1'b1;
                cnt = mem_lat;
                paddr = a;
            end
            if (busy) begin
                if (cnt <= 1) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data = ~paddr;
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: every decode handshake is checked against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got pc %h expected none",
                             bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", bus.inst_pc, e.pc);
                    chk("inst_data", bus.inst_data, e.data);
                end
                hs_cyc[hs_count % 64] = cyc;
                hs_count++;
            end
        end
    end

    task automatic consume(int n);
        int target;
        bit ok;
        target = hs_count + n;
        ok = 1'b0;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 20 * n; i++) begin
            @(posedge clk);
            #1;
            if (hs_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        bus.inst_ready = 1'b0;
        if (!ok) chk("consume_timeout", 32'(hs_count), 32'(target));
    endtask

    task automatic wait_hold();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.inst_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("hold_timeout", 32'(bus.inst_valid), 32'd1);
    endtask

    task automatic wait_wait();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (!bus.imem_req_valid && !bus.inst_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_timeout", 32'(bus.imem_req_valid), 32'd0);
    endtask

    task automatic redirect(logic [31:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = a;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b0;

        // Reset with a stray response on the bus.
        rst_inject = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        rst_inject = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("release_req_low", 32'(bus.imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_req_addr, 32'h0);

        // Sequential fetch, one instruction every 3 cycles.
        push(32'h0);
        push(32'h4);
        push(32'h8);
        consume(3);
        chk("rate_0_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
        chk("rate_1_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);

        // Decode stall: word held, no new request.
        wait_hold();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_pc", bus.inst_pc, 32'hC);
            chk("stall_data", bus.inst_data, ~32'hC);
            chk("stall_no_req", 32'(bus.imem_req_valid), 32'd0);
        end
        push(32'hC);
        consume(1);

        // Redirect in WAIT with response in the same cycle.
        wait_wait();
        redirect(32'h100);
        push(32'h100);
        consume(1);

        // Redirect in WAIT before the response: DRAIN path.
        mem_lat = 2;
        wait_wait();
        redirect(32'h200);
        push(32'h200);
        consume(1);
        mem_lat = 1;

        // Redirect in HOLD together with inst_ready.
        wait_hold();
        push(32'h204);
        bus.inst_ready = 1'b1;
        redirect(32'h40);
        bus.inst_ready = 1'b0;
        push(32'h40);
        consume(1);

        // Memory back-pressure: request stable, then replaced by redirect.
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("bp_req_addr", bus.imem_req_addr, 32'h44);
        end
        redirect(32'h80);
        chk("bp_redir_addr", bus.imem_req_addr, 32'h80);
        bus.imem_req_ready = 1'b1;
        push(32'h80);
        consume(1);

        // Redirect in FETCH as the request is accepted.
        redirect(32'h300);
        push(32'h300);
        consume(1);

        // Wrap past the top of the address space.
        redirect(32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        push(32'h0);
        consume(2);

        // Misaligned redirect target.
        redirect(32'h102);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("misalign_err", 32'(misalign_err), 32'd1);
        push(32'h4);
`else
        push(32'h100);
`endif
        consume(1);

        repeat (4) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-004 Port redirect_valid, input, 1, SHALL request that fetch restart at redirect_pc (branch/jal/jalr target from next-PC logic).
REQ-005 Port redirect_pc, input, 32, SHALL be the new fetch address, sampled when redirect_valid=1.
REQ-006 Port imem_req_valid, output, 1, SHALL mark a valid instruction-memory request.
REQ-007 Port imem_req_ready, input, 1, SHALL indicate that memory accepts the request.
REQ-008 Port imem_req_addr, output, 32, SHALL carry the fetch address.
REQ-009 Port imem_rsp_valid, input, 1, SHALL mark the returning instruction word.
REQ-010 Port imem_rsp_data, input, 32, SHALL carry the returning instruction word.
REQ-011 Port inst_valid, output, 1, SHALL mark a valid instruction presented to decode.
REQ-012 Port inst_ready, input, 1, SHALL indicate that decode accepts the instruction.
REQ-013 Port inst_data, output, 32, SHALL carry the instruction word.
REQ-014 Port inst_pc, output, 32, SHALL carry the address of inst_data (feeds pc input of next-PC logic).
REQ-015 Port misalign_err, output, 1, SHALL exist only when FETCH_MISALIGN_CHK_EN is defined.

Function
REQ-016 The FSM SHALL have four states: FETCH, WAIT, HOLD, DRAIN.
REQ-017 FETCH: imem_req_valid=1 and imem_req_addr=pc; on imem_req_ready=1 the FSM SHALL go to WAIT.
REQ-018 WAIT: on imem_rsp_valid=1 the unit SHALL latch inst_data=imem_rsp_data and inst_pc=pc, then go to HOLD.
REQ-019 HOLD: inst_valid=1; on inst_ready=1 the unit SHALL set pc=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0) and go to FETCH.
REQ-020 At most one memory request SHALL be outstanding; imem_req_valid SHALL be 0 outside FETCH.
REQ-021 Once asserted, imem_req_valid and imem_req_addr SHALL stay stable until imem_req_ready=1.
REQ-022 Once asserted, inst_valid and inst_data/inst_pc SHALL stay stable until inst_ready=1 or a redirect occurs.
REQ-023 Redirect in FETCH or HOLD SHALL set pc=redirect_pc, drop inst_valid the next cycle, and go to FETCH; a pending request not yet accepted SHALL be replaced by the new address.
REQ-024 Redirect in FETCH in the same cycle as imem_req_ready=1 SHALL set pc=redirect_pc and go to DRAIN.
REQ-025 Redirect in WAIT SHALL set pc=redirect_pc and go to DRAIN, or go to FETCH if imem_rsp_valid=1 in the same cycle; that response SHALL be discarded.
REQ-026 DRAIN SHALL discard the next response without presenting it, then go to FETCH; a redirect in DRAIN SHALL update pc only.
REQ-027 Redirect in HOLD in the same cycle as inst_ready=1 SHALL complete the handshake, and pc SHALL take redirect_pc, not pc+4.
REQ-028 Latency: with ready memory and a one-cycle response, a new instruction SHALL be presented every 3 cycles.

Reset
REQ-029 While rst_n=0: state=FETCH, pc=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, misalign_err=0, imem_req_valid=0.
REQ-030 imem_req_valid SHALL assert on the first clock edge after rst_n deasserts; any in-flight response during reset SHALL be ignored.

Configuration
REQ-031 With FETCH_MISALIGN_CHK_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL set misalign_err=1 (sticky until reset), SHALL NOT change pc, and SHALL NOT flush.
REQ-032 Without FETCH_MISALIGN_CHK_EN: the misalign_err port SHALL be absent, and redirect_pc SHALL be used with bits [1:0] forced to 0.

Verification
REQ-033 Reset release, always-ready memory, inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8, one instruction every 3 cycles.
REQ-034 Redirect to 0x100 while in WAIT -> the in-flight word is dropped and the next inst_pc is 0x100.
REQ-035 Redirect to 0x40 in HOLD in the same cycle as inst_ready=1 -> the current instruction is consumed and the next inst_pc is 0x40, not pc+4.
REQ-036 pc=0xFFFF_FFFC consumed -> the next imem_req_addr is 0x0000_0000.
REQ-037 inst_ready=0 for 5 cycles -> inst_data/inst_pc stay stable and no new imem request is issued.
REQ-038 With FETCH_MISALIGN_CHK_EN, redirect to 0x102 -> misalign_err=1, fetch continues sequentially; without it, fetch resumes at 0x100.
